// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   PS/2 keyboard front end for the T-rex game. Conditions the raw PS/2 pins,
//   receives 11-bit frames (start, 8 data LSB first, odd parity, stop), and
//   decodes scan-code set 2 make/break sequences into held key levels.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_data   raw PS/2 data pin (asynchronous)
//   rx_data    last correctly received byte
//   rx_valid   one-cycle strobe when rx_data is updated
//   frame_err  one-cycle strobe on parity, stop-bit or timeout error
//   key_up     Up arrow (E0 75) held
//   key_down   Down arrow (E0 72) held
//   key_space  Space (29) held
//   key_enter  Enter (5A) held
//   jump       key_up | key_space, registered
//   duck       key_down, registered
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       key_up,
    output logic       key_down,
    output logic       key_space,
    output logic       key_enter,
    output logic       jump,
    output logic       duck
);

    localparam int unsigned ToW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Input conditioning
    logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [FILTER_LEN-1:0] hist_q, hist_d;
    logic                  filt_q, filt_d;
    logic                  fall_q, fall_d;

    // Receiver
    state_e         state_q, state_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           frame_err_q, frame_err_d;

    // Decoder
    logic ext_q, ext_d, brk_q, brk_d;
    logic key_up_q, key_up_d, key_down_q, key_down_d;
    logic key_space_q, key_space_d, key_enter_q, key_enter_d;
    logic jump_q, jump_d, duck_q, duck_d;

    always_comb begin
        hist_d = {hist_q[FILTER_LEN-2:0], clk_s2_q};
        filt_d = filt_q;
        // Level only moves once the whole history agrees.
        if (&hist_q) begin
            filt_d = 1'b1;
        end else if (~|hist_q) begin
            filt_d = 1'b0;
        end
        fall_d = filt_q & ~filt_d;
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == StIdle || fall_q) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                // A high bit on a fall is not a start bit; ignore it silently.
                if (fall_q && !dat_s2_q) begin
                    state_d  = StData;
                    bitcnt_d = 3'd0;
                end
            end
            StData: begin
                if (fall_q) begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall_q) begin
                    parity_d = dat_s2_q;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fall_q) begin
                    if (dat_s2_q && (^{shift_q, parity_q})) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A stalled frame is dropped along with any partial data.
        if (state_q != StIdle && !fall_q && to_cnt_q == ToMax) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            shift_d     = '0;
            to_cnt_d    = '0;
        end
    end

    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        key_up_d    = key_up_q;
        key_down_d  = key_down_q;
        key_space_d = key_space_q;
        key_enter_d = key_enter_q;
        if (rx_valid_q) begin
            if (rx_data_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (rx_data_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                case ({ext_q, rx_data_q})
                    9'h175:  key_up_d    = ~brk_q;
                    9'h172:  key_down_d  = ~brk_q;
                    9'h029:  key_space_d = ~brk_q;
                    9'h05A:  key_enter_d = ~brk_q;
                    default: ;
                endcase
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        jump_d = key_up_q | key_space_q;
        duck_d = key_down_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            hist_q      <= '1;
            filt_q      <= 1'b1;
            fall_q      <= 1'b0;
            state_q     <= StIdle;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_up_q    <= 1'b0;
            key_down_q  <= 1'b0;
            key_space_q <= 1'b0;
            key_enter_q <= 1'b0;
            jump_q      <= 1'b0;
            duck_q      <= 1'b0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            hist_q      <= hist_d;
            filt_q      <= filt_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            to_cnt_q    <= to_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_up_q    <= key_up_d;
            key_down_q  <= key_down_d;
            key_space_q <= key_space_d;
            key_enter_q <= key_enter_d;
            jump_q      <= jump_d;
            duck_q      <= duck_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign key_up    = key_up_q;
    assign key_down  = key_down_q;
    assign key_space = key_space_q;
    assign key_enter = key_enter_q;
    assign jump      = jump_q;
    assign duck      = duck_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    localparam int unsigned FL   = 8;
    localparam int unsigned TO   = 1000;
    localparam int          HALF = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err;
    logic       key_up, key_down, key_space, key_enter, jump, duck;

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_space (key_space),
        .key_enter (key_enter),
        .jump      (jump),
        .duck      (duck)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    int   nvalid = 0, nerr = 0;
    int   valid_cyc = 0, err_cyc = 0, jump_rise_cyc = 0;
    logic jump_prev = 1'b0;
    always @(negedge clk) begin
        if (rx_valid) begin
            nvalid++;
            valid_cyc = cyc;
        end
        if (frame_err) begin
            nerr++;
            err_cyc = cyc;
        end
        if (jump && !jump_prev) jump_rise_cyc = cyc;
        jump_prev = jump;
    end

    int total = 0;
    int bad   = 0;
    int last_fall_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural model: key map plus prefix flags, applied per received byte.
    logic [3:0] mkeys = 4'b0000;  // {up, down, space, enter}
    bit         mext = 0, mbrk = 0;
    logic [7:0] exp_rx = 8'h00;

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) mext = 1;
        else if (b == 8'hF0) mbrk = 1;
        else begin
            if (mext && b == 8'h75) mkeys[3] = !mbrk;
            if (mext && b == 8'h72) mkeys[2] = !mbrk;
            if (!mext && b == 8'h29) mkeys[1] = !mbrk;
            if (!mext && b == 8'h5A) mkeys[0] = !mbrk;
            mext = 0;
            mbrk = 0;
        end
    endtask

    // Drives the first nbits of a frame; optional 3-cycle clock glitches.
    task automatic send_frame(input logic [7:0] b, input bit flip, input bit glitch,
                              input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ flip, b, 1'b0};
        if (glitch) begin
            tick(10); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(20);
        end
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(5);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
            if (glitch && i == 4) begin
                tick(10); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(HALF - 18);
            end else begin
                tick(HALF - 5);
            end
        end
        ps2_data = 1'b1;
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input bit flip,
                            input bit glitch, input logic [3:0] keys);
        int v0, e0;
        v0 = nvalid;
        e0 = nerr;
        send_frame(b, flip, glitch, 11);
        tick(10);
        if (!flip) exp_rx = b;
        check({tag, " valid"}, nvalid - v0, flip ? 0 : 1);
        check({tag, " err"}, nerr - e0, flip ? 1 : 0);
        check({tag, " rx_data"}, int'(rx_data), int'(exp_rx));
        check({tag, " keys"}, int'({key_up, key_down, key_space, key_enter}), int'(keys));
        check({tag, " jump"}, int'(jump), int'(keys[3] | keys[1]));
        check({tag, " duck"}, int'(duck), int'(keys[2]));
    endtask

    typedef struct {
        logic [7:0] code;
        bit         flip;
        logic [3:0] keys;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int v0, e0, lat;
        logic [7:0] b;
        bit flip, gl;

        tbl[0]  = '{8'h29, 1'b0, 4'b0010};
        tbl[1]  = '{8'hE0, 1'b0, 4'b0010};
        tbl[2]  = '{8'h75, 1'b0, 4'b1010};
        tbl[3]  = '{8'hE0, 1'b0, 4'b1010};
        tbl[4]  = '{8'hF0, 1'b0, 4'b1010};
        tbl[5]  = '{8'h75, 1'b0, 4'b0010};
        tbl[6]  = '{8'h75, 1'b0, 4'b0010};
        tbl[7]  = '{8'hF0, 1'b0, 4'b0010};
        tbl[8]  = '{8'h29, 1'b0, 4'b0000};
        tbl[9]  = '{8'h5A, 1'b1, 4'b0000};
        tbl[10] = '{8'h5A, 1'b0, 4'b0001};
        tbl[11] = '{8'h5A, 1'b0, 4'b0001};
        tbl[12] = '{8'hF0, 1'b0, 4'b0001};
        tbl[13] = '{8'h5A, 1'b0, 4'b0000};

        tick(5);
        rst = 1'b0;
        tick(2);
        check("reset rx_data", int'(rx_data), 0);
        check("reset strobes", int'({rx_valid, frame_err}), 0);
        check("reset keys", int'({key_up, key_down, key_space, key_enter, jump, duck}), 0);
        tick(20);

        for (int i = 0; i < 14; i++) begin
            if (!tbl[i].flip) model_byte(tbl[i].code);
            do_frame($sformatf("vec%0d", i), tbl[i].code, tbl[i].flip, (i % 3) == 0,
                     tbl[i].keys);
            if (i == 0) begin
                lat = valid_cyc - last_fall_cyc;
                check("rx latency ok", int'(lat > 0 && lat <= 2 + int'(FL) + 2), 1);
                check("jump latency ok", int'(jump_rise_cyc - valid_cyc <= 2 &&
                                              jump_rise_cyc > valid_cyc), 1);
            end
        end

        // Stalled frame: start + 4 data bits, then clock idles high.
        v0 = nvalid;
        e0 = nerr;
        send_frame(8'h72, 1'b0, 1'b0, 5);
        for (int i = 0; i < int'(TO) + 100 && nerr == e0; i++) tick(1);
        check("timeout err", nerr - e0, 1);
        lat = err_cyc - last_fall_cyc;
        check("timeout latency ok", int'(lat >= int'(TO) && lat <= int'(TO) + 14), 1);
        check("timeout no valid", nvalid - v0, 0);
        tick(20);
        model_byte(8'hE0);
        do_frame("dn_e0", 8'hE0, 1'b0, 1'b0, mkeys);
        model_byte(8'h72);
        do_frame("dn_72", 8'h72, 1'b0, 1'b0, mkeys);
        check("duck set", int'(duck), 1);

        // Reset after the 5th data bit while key_down is held.
        send_frame(8'hA5, 1'b0, 1'b0, 6);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst outputs",
              int'({rx_data, rx_valid, frame_err, key_up, key_down, key_space, key_enter,
                    jump, duck}), 0);
        mkeys = 4'b0000; mext = 0; mbrk = 0; exp_rx = 8'h00;
        tick(20);
        model_byte(8'h29);
        do_frame("post_rst", 8'h29, 1'b0, 1'b0, mkeys);

        // Randomized sequence checked against the byte-level model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'h75;
                3: b = 8'h72;
                4: b = 8'h29;
                5: b = 8'h5A;
                default: b = 8'($urandom_range(0, 255));
            endcase
            flip = ($urandom_range(0, 5) == 0);
            gl   = ($urandom_range(0, 1) == 1);
            if (!flip) model_byte(b);
            do_frame($sformatf("rnd%0d", i), b, flip, gl, mkeys);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
